// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch unit and its entry queue.
package fetch_pkg;

    typedef enum logic [1:0] {
        ST_BOOT,
        ST_RUN,
        ST_HALTED
    } fetch_state_t;

    typedef struct packed {
        logic [63:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

    localparam logic [63:0] PC_STEP           = 64'd4;
    localparam logic [31:0] HALT_WORD_DEFAULT = 32'hD440_0000;

    // Redirect targets are forced onto a word boundary.
    function automatic logic [63:0] align_target(input logic [63:0] target);
        return {target[63:2], 2'b00};
    endfunction

endpackage

// File: rtl/instruction_fetch_if.sv
// Fetch-unit bus: instruction memory port, redirect request and decode handshake.
interface instruction_fetch_if;

    logic [63:0] adr;
    logic [31:0] Instruction;
    logic        br_taken;
    logic [63:0] br_target;
    logic        fetch_valid;
    logic [31:0] fetch_instr;
    logic [63:0] fetch_pc;
    logic        fetch_ready;
    logic        halted;

    modport master (
        output adr, fetch_valid, fetch_instr, fetch_pc, halted,
        input  Instruction, br_taken, br_target, fetch_ready
    );

    modport slave (
        input  adr, fetch_valid, fetch_instr, fetch_pc, halted,
        output Instruction, br_taken, br_target, fetch_ready
    );

endinterface

// File: rtl/fetch_queue.sv
// Circular FIFO of fetched {pc, instr} entries with flush; push and pop together is legal when full.
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         push,
    input  logic                         pop,
    input  logic                         flush,
    input  fetch_entry_t                 wdata,
    output fetch_entry_t                 head,
    output logic                         full,
    output logic                         empty,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    fetch_entry_t          mem [DEPTH];
    logic [PW-1:0]         rd_ptr;
    logic [PW-1:0]         wr_ptr;
    logic                  do_push;
    logic                  do_pop;

    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= next_ptr(wr_ptr);
            if (do_pop)  rd_ptr <= next_ptr(rd_ptr);
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage carries no reset; the pointers alone define which slots are live.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/instruction_fetch.sv
// Instruction fetch: pc/FSM control feeding a small queue toward decode, with redirect and halt.
module instruction_fetch
    import fetch_pkg::*;
#(
    parameter logic [63:0] RESET_PC    = 64'h0,
    parameter int          QUEUE_DEPTH = 2,
    parameter logic [31:0] HALT_WORD   = HALT_WORD_DEFAULT
) (
    input  logic                 clk,
    input  logic                 rst_n,
    instruction_fetch_if.master  bus
);

    localparam int CW = $clog2(QUEUE_DEPTH + 1);

    fetch_state_t   state;
    logic [63:0]    pc;
    logic           halted_r;
    logic           redirect;
    logic           pop;
    logic           push;
    logic           is_halt;
    logic           q_full;
    logic           q_empty;
    logic [CW-1:0]  q_count;
    fetch_entry_t   q_head;
    fetch_entry_t   q_wdata;

    // Redirect outranks everything; it is ignored only in BOOT.
    assign redirect = bus.br_taken && (state != ST_BOOT);
    assign pop      = !q_empty && bus.fetch_ready && !redirect;
    assign push     = (state == ST_RUN) && !redirect && (!q_full || pop);
    assign is_halt  = (bus.Instruction == HALT_WORD);
    assign q_wdata  = '{pc: pc, instr: bus.Instruction};

    fetch_queue #(
        .DEPTH (QUEUE_DEPTH)
    ) u_queue (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .pop   (pop),
        .flush (redirect),
        .wdata (q_wdata),
        .head  (q_head),
        .full  (q_full),
        .empty (q_empty),
        .count (q_count)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= ST_BOOT;
            pc       <= RESET_PC;
            halted_r <= 1'b0;
        end else begin
            case (state)
                ST_BOOT: begin
                    state    <= ST_RUN;
                    halted_r <= 1'b0;
                end
                default: begin
                    if (redirect) begin
                        pc       <= align_target(bus.br_target);
                        state    <= ST_RUN;
                        halted_r <= 1'b0;
                    end else if (push) begin
                        if (is_halt) begin
                            state    <= ST_HALTED;
                            halted_r <= 1'b1;
                        end else begin
                            pc <= pc + PC_STEP;
                        end
                    end
                end
            endcase
        end
    end

    assign bus.adr         = pc;
    assign bus.halted      = halted_r;
    assign bus.fetch_valid = (q_count != '0);
    assign bus.fetch_instr = q_empty ? 32'h0 : q_head.instr;
    assign bus.fetch_pc    = q_empty ? 64'h0 : q_head.pc;

endmodule

// File: tb/tb_instruction_fetch.sv
// Randomized scoreboard bench for instruction_fetch against a queue-based reference model.
module tb_instruction_fetch;

    localparam logic [63:0] RESET_PC = 64'h0;
    localparam int          DEPTH    = 2;
    localparam logic [31:0] HW       = 32'hD440_0000;

    typedef struct {
        logic [63:0] pc;
        logic [31:0] instr;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    instruction_fetch_if bus();

    instruction_fetch #(
        .RESET_PC    (RESET_PC),
        .QUEUE_DEPTH (DEPTH),
        .HALT_WORD   (HW)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    logic [31:0] salt;
    logic [63:0] halt_addr;
    logic        halt_en;

    function automatic logic [31:0] mem_word(input logic [63:0] a, input logic [31:0] s,
                                             input logic [63:0] ha, input logic he);
        logic [31:0] w;
        if (he && a == ha) return HW;
        w = a[31:0] ^ a[63:32] ^ s;
        if (w == HW) w = w ^ 32'h1;
        return w;
    endfunction

    assign bus.Instruction = mem_word(bus.adr, salt, halt_addr, halt_en);

    // Reference model: expected queue contents, pc and state (0 boot, 1 run, 2 halted).
    exp_t        exp_q[$];
    logic [63:0] m_pc;
    int          m_state;
    bit          m_valid = 1'b0;
    int          checks = 0;
    int          failures = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: mid-cycle, compare DUT outputs to the model and retire accepted heads.
    initial begin
        forever begin
            @(negedge clk);
            if (m_valid) begin
                check("adr", bus.adr, m_pc);
                check("halted", 64'(bus.halted), 64'(m_state == 2));
                check("fetch_valid", 64'(bus.fetch_valid), 64'(exp_q.size() != 0));
                if (exp_q.size() != 0) begin
                    check("fetch_pc", bus.fetch_pc, exp_q[0].pc);
                    check("fetch_instr", 64'(bus.fetch_instr), 64'(exp_q[0].instr));
                    if (bus.fetch_ready) void'(exp_q.pop_front());
                end else begin
                    check("fetch_pc_empty", bus.fetch_pc, 64'h0);
                    check("fetch_instr_empty", 64'(bus.fetch_instr), 64'h0);
                end
            end
        end
    end

    // Drive one cycle of inputs, predict the effect of the coming edge, apply it after the edge.
    task automatic step(input bit r, input bit rdy, input bit br, input logic [63:0] tgt);
        bit          do_flush = 1'b0;
        bit          do_push = 1'b0;
        bit          pop;
        exp_t        e;
        logic [63:0] npc = m_pc;
        int          nst = m_state;
        int          sz = exp_q.size();
        rst_n           = r;
        bus.fetch_ready = rdy;
        bus.br_taken    = br;
        bus.br_target   = tgt;
        if (!r) begin
            npc      = RESET_PC;
            nst      = 0;
            do_flush = 1'b1;
        end else if (m_valid) begin
            if (m_state == 0) begin
                nst = 1;
            end else if (br) begin
                do_flush = 1'b1;
                npc      = {tgt[63:2], 2'b00};
                nst      = 1;
            end else begin
                pop = (sz > 0) && rdy;
                if (m_state == 1 && (sz < DEPTH || pop)) begin
                    e.pc    = m_pc;
                    e.instr = mem_word(m_pc, salt, halt_addr, halt_en);
                    do_push = 1'b1;
                    if (e.instr == HW) nst = 2;
                    else npc = m_pc + 64'd4;
                end
            end
        end
        @(posedge clk);
        #1;
        if (do_flush) exp_q.delete();
        if (do_push) exp_q.push_back(e);
        m_pc    = npc;
        m_state = nst;
        if (!r) m_valid = 1'b1;
    endtask

    task automatic run(input int n, input bit rdy);
        for (int i = 0; i < n; i++) step(1'b1, rdy, 1'b0, 64'h0);
    endtask

    initial begin
        logic [63:0] tgt;
        bit          r;
        bit          br;
        salt      = 32'h0;
        halt_addr = 64'h0;
        halt_en   = 1'b0;
        m_pc      = RESET_PC;
        m_state   = 0;

        // Memory word equals address; sequential fetch from reset.
        step(1'b0, 1'b1, 1'b0, 64'h0);
        step(1'b0, 1'b1, 1'b1, 64'h80);
        run(8, 1'b1);

        // Decode stalled: queue fills with pc 0 and 4, adr holds at 8.
        step(1'b0, 1'b0, 1'b0, 64'h0);
        run(6, 1'b0);
        run(5, 1'b1);

        // Redirect with two entries queued.
        step(1'b0, 1'b0, 1'b0, 64'h0);
        run(5, 1'b0);
        step(1'b1, 1'b1, 1'b1, 64'h43);
        run(6, 1'b1);

        // Halt word at 0x10, then resume via redirect to 0.
        halt_en   = 1'b1;
        halt_addr = 64'h10;
        step(1'b0, 1'b1, 1'b0, 64'h0);
        run(12, 1'b1);
        step(1'b1, 1'b1, 1'b1, 64'h0);
        run(4, 1'b1);

        // Full queue while halted, then a single-cycle reset.
        halt_addr = 64'h4;
        step(1'b0, 1'b0, 1'b0, 64'h0);
        run(6, 1'b0);
        step(1'b0, 1'b0, 1'b0, 64'h0);
        run(4, 1'b1);

        // pc wraps past the top of the address space.
        halt_en = 1'b0;
        step(1'b1, 1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_FFFB);
        run(7, 1'b1);

        // Randomized traffic.
        for (int i = 0; i < 1500; i++) begin
            r  = ($urandom_range(99) != 0);
            br = ($urandom_range(99) < 5);
            case ($urandom_range(2))
                0:       tgt = {$urandom(), $urandom()};
                1:       tgt = 64'($urandom_range(63));
                default: tgt = 64'hFFFF_FFFF_FFFF_FFF0 + 64'($urandom_range(15));
            endcase
            if (!r) begin
                salt      = $urandom();
                halt_en   = $urandom_range(1) == 1;
                halt_addr = 64'({$urandom_range(15), 2'b00});
            end
            step(r, $urandom_range(99) < 70, br, tgt);
        end
        run(3, 1'b1);

        @(negedge clk);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/instruction_fetch.md
INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

Interface
REQ-001 Parameter RESET_PC, default 64'h0: program counter value loaded by reset.
REQ-002 Parameter QUEUE_DEPTH, default 2: number of fetch-queue entries; legal range 2..8.
REQ-003 Parameter HALT_WORD, default 32'hD4400000: instruction encoding that stops sequential fetch.
REQ-004 clk  input  1: single clock; all state updates on the rising edge.
REQ-005 rst_n  input  1: reset, synchronous, active-low.
REQ-006 adr  output  64: byte address presented to the combinational instruction memory.
REQ-007 Instruction  input  32: memory word for adr, valid in the same cycle.
REQ-008 br_taken  input  1: redirect request from execute.
REQ-009 br_target  input  64: redirect address, sampled when br_taken=1.
REQ-010 fetch_valid  output  1: queue head holds a valid instruction.
REQ-011 fetch_instr  output  32: queue head instruction.
REQ-012 fetch_pc  output  64: address of the queue head instruction.
REQ-013 fetch_ready  input  1: decode accepts the head this cycle.
REQ-014 halted  output  1: high while the FSM is in HALTED.

Function
REQ-015 FSM states: BOOT, RUN, HALTED.
REQ-016 BOOT lasts exactly one cycle after reset release, performs no fetch, then goes to RUN.
REQ-017 adr SHALL equal the pc register in every state.
REQ-018 Push condition, RUN only: no br_taken, and (count < QUEUE_DEPTH, or a pop occurs in the same cycle).
REQ-019 Push action: enqueue {pc, Instruction}; pc <= pc + 4, modulo 2^64, so 64'hFFFF_FFFF_FFFF_FFFC wraps to 0.
REQ-020 Queue full with no pop: no push; pc holds; adr stays stable.
REQ-021 Pop: occurs when fetch_valid && fetch_ready; head advances the next cycle.
REQ-022 fetch_valid = (count != 0); fetch_instr and fetch_pc SHALL be 0 when the queue is empty.
REQ-023 Pushing an instruction equal to HALT_WORD: push it, then enter HALTED; pc does not advance.
REQ-024 HALTED: no pushes; queued entries continue to drain through pops.
REQ-025 br_taken=1 in any state except BOOT:
  - flush all queue entries; a same-cycle pop is discarded;
  - suppress that cycle's push;
  - pc <= {br_target[63:2], 2'b00};
  - state <= RUN.
REQ-026 br_taken during BOOT: ignored.
REQ-027 Redirect takes priority over push, pop and halt detection.
REQ-028 Latency: an instruction fetched in cycle N is visible at the outputs in cycle N+1 if the queue was empty.
REQ-029 Throughput: one instruction per cycle sustained while fetch_ready=1 and no redirect occurs.

Reset
REQ-030 rst_n=0 at a rising edge:
  - pc <= RESET_PC;
  - queue emptied, count <= 0;
  - state <= BOOT.
REQ-031 Outputs during reset and BOOT: fetch_valid=0, fetch_instr=0, fetch_pc=0, halted=0, adr=RESET_PC.
REQ-032 Reset asserted mid-operation (including HALTED or a full queue): discards all state within one edge; no entry survives.

Structure
REQ-033 Shared package fetch_pkg holds:
  - fetch_state_t enum;
  - fetch_entry_t struct {pc[63:0], instr[31:0]};
  - constant PC_STEP = 4;
  - HALT_WORD default.
REQ-034 The queue SHALL be the sub-module fetch_queue:
  - circular FIFO of fetch_entry_t;
  - push, pop and flush inputs; full, empty and count outputs;
  - simultaneous push and pop when full is legal.
REQ-035 FSM and pc logic reside in instruction_fetch; no combinational path from fetch_ready to adr.

Verification
REQ-036 Reset release with RESET_PC=0, memory word = address, fetch_ready=1 -> fetch_pc sequence 0,4,8,12; first fetch_valid two cycles after reset release.
REQ-037 fetch_ready=0 for 5 cycles -> exactly 2 entries (pc 0,4) queued; adr held at 8; pc 0 delivered first once ready returns.
REQ-038 br_taken=1, br_target=64'h43 while 2 entries are queued -> queue empties next cycle; next fetch_pc=64'h40; no stale entry appears.
REQ-039 Word at 64'h10 = HALT_WORD -> pc 0..16 delivered; halted=1; no further pushes; br_taken to 64'h0 -> halted=0 and fetch resumes at 0.
REQ-040 RESET_PC=64'hFFFF_FFFF_FFFF_FFF8 -> fetch_pc sequence ...FFF8, ...FFFC, 0, 4.
REQ-041 rst_n=0 for one cycle with a full queue and halted=1 -> next cycle fetch_valid=0, halted=0, adr=RESET_PC.
